// File: rtl/radio_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : radio_frame_pkg
// Brief    : Shared types and helpers for the radio frame de-interleaver.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package radio_frame_pkg;

    // Framing state: hunting for a group start, or locked to the pattern
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } frame_state_t;

    // Out-of-range channel counts (0 or above the build maximum) fall back to one channel
    function automatic int clamp_nc(input int num_chan, input int max_chan);
        if ((num_chan < 1) || (num_chan > max_chan)) begin
            return 1;
        end
        return num_chan;
    endfunction

    // Pair index within a group to output channel; reverse covers a swapped converter/PCB
    function automatic int chan_map(input int p, input int nc, input logic reverse);
        if (reverse) begin
            return nc - 1 - p;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/radio_frame_err_cnt.sv
`default_nettype none
// ============================================================================
// Module   : radio_frame_err_cnt
// Brief    : Saturating framing-error counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module radio_frame_err_cnt
    import radio_frame_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] r_count;

    // Clear wins over the old value, but an error in the same cycle is still counted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= inc ? ERR_W'(1) : '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + ERR_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/radio_frame_deinterleaver.sv
`default_nettype none
// ============================================================================
// Module   : radio_frame_deinterleaver
// Brief    : Locks to the frame-bit pattern of an I/Q word stream, rebuilds
//            up to MAX_CHAN channels and strobes one aligned set per group.
// Revision : 1.0 - parametrised single-clock successor of the 2-channel block
// ============================================================================
module radio_frame_deinterleaver
    import radio_frame_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int MAX_CHAN = 4,
    parameter bit REVERSE  = 1'b1,
    parameter int ERR_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [$clog2(MAX_CHAN):0] num_chan,
    input  logic                      in_valid,
    input  logic                      in_frame,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      err_clear,
    output logic                      out_valid,
    output logic [MAX_CHAN*WIDTH-1:0] out_i,
    output logic [MAX_CHAN*WIDTH-1:0] out_q,
    output logic                      locked,
    output logic [ERR_W-1:0]          err_count
);

    // Position counter needs 0..2*MAX_CHAN-1, same width as the channel count
    localparam int c_NC_W  = $clog2(MAX_CHAN) + 1;
    localparam int c_BUS_W = MAX_CHAN * WIDTH;

    frame_state_t        r_state, w_state_nxt;
    logic [c_NC_W-1:0]   r_pos, w_pos_nxt;
    logic [c_NC_W-1:0]   r_nc, w_nc_nxt;
    logic                r_prev_frame, w_prev_frame_nxt;
    logic [c_BUS_W-1:0]  r_asm_i, r_asm_q, w_asm_i_nxt, w_asm_q_nxt;
    logic [c_BUS_W-1:0]  r_out_i, r_out_q, w_out_i_nxt, w_out_q_nxt;
    logic                r_out_valid;

    logic [c_NC_W-1:0]   w_nc_in;
    logic [c_NC_W:0]     w_last_pos;
    logic                w_exp_frame;
    logic                w_start;
    logic                w_store_en;
    logic [c_NC_W-1:0]   w_store_pos;
    logic [c_NC_W-1:0]   w_store_nc;
    int                  w_store_chan;
    logic                w_complete;
    logic                w_err_inc;

    assign w_nc_in      = c_NC_W'(clamp_nc(int'(num_chan), MAX_CHAN));
    assign w_last_pos   = {r_nc, 1'b0} - (c_NC_W + 1)'(1);
    assign w_exp_frame  = (r_pos < r_nc);
    assign w_start      = in_frame & ~r_prev_frame;
    assign w_store_chan = chan_map(int'(w_store_pos >> 1), int'(w_store_nc), REVERSE);

    // Framing FSM: next state, position, latched channel count and store/strobe decisions
    always_comb begin
        w_state_nxt      = r_state;
        w_pos_nxt        = r_pos;
        w_nc_nxt         = r_nc;
        w_prev_frame_nxt = r_prev_frame;
        w_store_en       = 1'b0;
        w_store_pos      = r_pos;
        w_store_nc       = r_nc;
        w_complete       = 1'b0;
        w_err_inc        = 1'b0;
        if (in_valid) begin
            w_prev_frame_nxt = in_frame;
            case (r_state)
                HUNT: begin
                    if (w_start) begin
                        w_state_nxt = LOCK;
                        w_nc_nxt    = w_nc_in;
                        w_pos_nxt   = c_NC_W'(1);
                        w_store_en  = 1'b1;
                        w_store_pos = '0;
                        w_store_nc  = w_nc_in;
                    end
                end
                LOCK: begin
                    if (w_nc_in != r_nc) begin
                        // Channel count changed under us: drop the group quietly
                        w_state_nxt = HUNT;
                    end else if (in_frame == w_exp_frame) begin
                        w_store_en = 1'b1;
                        if ({1'b0, r_pos} == w_last_pos) begin
                            w_complete = 1'b1;
                            w_pos_nxt  = '0;
                        end else begin
                            w_pos_nxt = r_pos + c_NC_W'(1);
                        end
                    end else begin
                        w_err_inc = 1'b1;
                        if (w_start) begin
                            // Offending word is itself a clean group start: restart in place
                            w_pos_nxt   = c_NC_W'(1);
                            w_store_en  = 1'b1;
                            w_store_pos = '0;
                        end else begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Steer the accepted word into its channel slot; on completion copy the set out, zeroing unused channels
    always_comb begin
        w_asm_i_nxt = r_asm_i;
        w_asm_q_nxt = r_asm_q;
        w_out_i_nxt = r_out_i;
        w_out_q_nxt = r_out_q;
        for (int c = 0; c < MAX_CHAN; c++) begin
            if (w_store_en && (c == w_store_chan)) begin
                if (w_store_pos[0]) begin
                    w_asm_q_nxt[c*WIDTH +: WIDTH] = in_data;
                end else begin
                    w_asm_i_nxt[c*WIDTH +: WIDTH] = in_data;
                end
            end
            if (w_complete) begin
                if (c < int'(r_nc)) begin
                    w_out_i_nxt[c*WIDTH +: WIDTH] = w_asm_i_nxt[c*WIDTH +: WIDTH];
                    w_out_q_nxt[c*WIDTH +: WIDTH] = w_asm_q_nxt[c*WIDTH +: WIDTH];
                end else begin
                    w_out_i_nxt[c*WIDTH +: WIDTH] = '0;
                    w_out_q_nxt[c*WIDTH +: WIDTH] = '0;
                end
            end
        end
    end

    // State and datapath registers; prev-frame resets high so the first frame=1 after reset is not a start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= HUNT;
            r_pos        <= '0;
            r_nc         <= c_NC_W'(1);
            r_prev_frame <= 1'b1;
            r_asm_i      <= '0;
            r_asm_q      <= '0;
            r_out_i      <= '0;
            r_out_q      <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_nc         <= w_nc_nxt;
            r_prev_frame <= w_prev_frame_nxt;
            r_asm_i      <= w_asm_i_nxt;
            r_asm_q      <= w_asm_q_nxt;
            r_out_i      <= w_out_i_nxt;
            r_out_q      <= w_out_q_nxt;
            r_out_valid  <= w_complete;
        end
    end

    radio_frame_err_cnt #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (err_clear),
        .inc     (w_err_inc),
        .count   (err_count)
    );

    assign out_valid = r_out_valid;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign locked    = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_radio_frame_deinterleaver.sv
`default_nettype none
// ============================================================================
// Module   : tb_radio_frame_deinterleaver
// Brief    : Self-checking bench with a word-queue model of the de-interleaver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radio_frame_deinterleaver;

    localparam int WIDTH    = 12;
    localparam int MAX_CHAN = 4;
    localparam bit REV      = 1'b1;
    // Narrow counter so saturation is reachable in a short run
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b1;
    logic [2:0]                num_chan = 3'd1;
    logic                      in_valid = 1'b0;
    logic                      in_frame = 1'b0;
    logic [WIDTH-1:0]          in_data = '0;
    logic                      err_clear = 1'b0;
    logic                      out_valid;
    logic [MAX_CHAN*WIDTH-1:0] out_i;
    logic [MAX_CHAN*WIDTH-1:0] out_q;
    logic                      locked;
    logic [ERR_W-1:0]          err_count;

    radio_frame_deinterleaver #(
        .WIDTH    (WIDTH),
        .MAX_CHAN (MAX_CHAN),
        .REVERSE  (REV),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .num_chan  (num_chan),
        .in_valid  (in_valid),
        .in_frame  (in_frame),
        .in_data   (in_data),
        .err_clear (err_clear),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .locked    (locked),
        .err_count (err_count)
    );

    initial forever #5 clk = ~clk;

    // ---------------- model state ----------------
    bit               m_lock;
    bit               m_prev;
    int               m_nc;
    int               m_err;
    int               m_strobes;
    logic [WIDTH-1:0] m_words[$];
    bit               e_valid;
    logic [WIDTH-1:0] e_i[MAX_CHAN];
    logic [WIDTH-1:0] e_q[MAX_CHAN];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic model_reset();
        m_lock  = 1'b0;
        m_prev  = 1'b1;
        m_nc    = 1;
        m_err   = 0;
        e_valid = 1'b0;
        m_words.delete();
        for (int c = 0; c < MAX_CHAN; c++) begin
            e_i[c] = '0;
            e_q[c] = '0;
        end
    endtask

    // One clock edge of behaviour, from the current tb inputs
    task automatic model_step();
        int  nce;
        int  ch;
        bit  start;
        e_valid = 1'b0;
        if (err_clear) m_err = 0;
        if (!in_valid) return;
        nce   = (num_chan == 3'd0 || int'(num_chan) > MAX_CHAN) ? 1 : int'(num_chan);
        start = in_frame && !m_prev;
        if (!m_lock) begin
            if (start) begin
                m_lock = 1'b1;
                m_nc   = nce;
                m_words.delete();
                m_words.push_back(in_data);
            end
        end else if (nce != m_nc) begin
            m_lock = 1'b0;
            m_words.delete();
        end else if (in_frame == (m_words.size() < m_nc)) begin
            m_words.push_back(in_data);
            if (m_words.size() == 2 * m_nc) begin
                e_valid = 1'b1;
                m_strobes++;
                for (int c = 0; c < MAX_CHAN; c++) begin
                    e_i[c] = '0;
                    e_q[c] = '0;
                end
                for (int k = 0; k < m_nc; k++) begin
                    ch = REV ? (m_nc - 1 - k) : k;
                    e_i[ch] = m_words[2*k];
                    e_q[ch] = m_words[2*k+1];
                end
                m_words.delete();
            end
        end else begin
            if (m_err < ERR_MAX) m_err++;
            m_words.delete();
            if (start) m_words.push_back(in_data);
            else m_lock = 1'b0;
        end
        m_prev = in_frame;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("err_count", 32'(err_count), 32'(m_err));
        for (int c = 0; c < MAX_CHAN; c++) begin
            chk($sformatf("out_i[%0d]", c), 32'(out_i[c*WIDTH +: WIDTH]), 32'(e_i[c]));
            chk($sformatf("out_q[%0d]", c), 32'(out_q[c*WIDTH +: WIDTH]), 32'(e_q[c]));
        end
    endtask

    // Drive one cycle (called at a falling edge), step the model at the rising edge, check at the next falling edge
    task automatic cycle(input bit v, input bit f, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_frame = f;
        in_data  = d;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        err_clear = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int               s0;
        int               tp;
        int               nce;
        bit               f;
        logic [WIDTH-1:0] w0;
        logic [WIDTH-1:0] w7;

        m_strobes = 0;
        #3;
        do_reset();
        chk("reset_model_err", 32'(m_err), 32'd0);

        // SISO: 8 groups A/B
        num_chan = 3'd1;
        s0 = m_strobes;
        cycle(1'b1, 1'b0, 12'hB00);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1, {4'hA, 8'(k)});
            cycle(1'b1, 1'b0, {4'hB, 8'(k)});
        end
        cycle(1'b0, 1'b0, '0);
        chk("siso_strobes", 32'(m_strobes - s0), 32'd8);
        chk("siso_i0", 32'(e_i[0]), 32'h0A07);
        chk("siso_q0", 32'(e_q[0]), 32'h0B07);
        chk("siso_i1_zero", 32'(e_i[1]), 32'h0);

        // MIMO 2 channels: C,D then A,B per group
        do_reset();
        num_chan = 3'd2;
        s0 = m_strobes;
        cycle(1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, {4'hC, 8'(k)});
            cycle(1'b1, 1'b1, {4'hD, 8'(k)});
            cycle(1'b1, 1'b0, {4'hA, 8'(k)});
            cycle(1'b1, 1'b0, {4'hB, 8'(k)});
        end
        chk("mimo_strobes", 32'(m_strobes - s0), 32'd6);
        chk("mimo_i1", 32'(e_i[1]), 32'h0C05);
        chk("mimo_q1", 32'(e_q[1]), 32'h0D05);
        chk("mimo_i0", 32'(e_i[0]), 32'h0A05);
        chk("mimo_q0", 32'(e_q[0]), 32'h0B05);
        chk("mimo_i2_zero", 32'(e_i[2]), 32'h0);

        // Four channels with in_valid toggling every cycle
        do_reset();
        num_chan = 3'd4;
        s0 = m_strobes;
        w0 = '0;
        w7 = '0;
        cycle(1'b1, 1'b0, '0);
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 8; p++) begin
                in_data = 12'($urandom);
                if (p == 0) w0 = in_data;
                if (p == 7) w7 = in_data;
                cycle(1'b1, (p < 4), in_data);
                cycle(1'b0, 1'($urandom), 12'($urandom));
            end
        end
        chk("nc4_strobes", 32'(m_strobes - s0), 32'd4);
        chk("nc4_ch3_i", 32'(e_i[3]), 32'(w0));
        chk("nc4_ch0_q", 32'(e_q[0]), 32'(w7));

        // MIMO with the frame bit of word 5 flipped
        do_reset();
        num_chan = 3'd2;
        s0 = m_strobes;
        cycle(1'b1, 1'b0, '0);
        for (int w = 0; w < 12; w++) begin
            f = ((w % 4) < 2);
            if (w == 5) f = !f;
            cycle(1'b1, f, 12'(w));
        end
        chk("flip_err", 32'(m_err), 32'd1);
        chk("flip_strobes", 32'(m_strobes - s0), 32'd2);

        // num_chan 2 -> 1 mid-group, then SISO
        cycle(1'b1, 1'b1, 12'hC10);
        cycle(1'b1, 1'b1, 12'hD10);
        num_chan = 3'd1;
        cycle(1'b1, 1'b0, 12'hA10);
        s0 = m_strobes;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, {4'hA, 8'(k)});
            cycle(1'b1, 1'b0, {4'hB, 8'(k)});
        end
        chk("ncchg_err", 32'(m_err), 32'd1);
        chk("ncchg_strobes", 32'(m_strobes - s0), 32'd3);
        chk("ncchg_i0", 32'(e_i[0]), 32'h0A02);
        chk("ncchg_i1_zero", 32'(e_i[1]), 32'h0);

        // Error then error coinciding with err_clear
        cycle(1'b1, 1'b0, 12'h001);
        cycle(1'b1, 1'b1, 12'h002);
        err_clear = 1'b1;
        cycle(1'b1, 1'b1, 12'h003);
        err_clear = 1'b0;
        chk("clr_with_err", 32'(m_err), 32'd1);
        err_clear = 1'b1;
        cycle(1'b0, 1'b0, '0);
        err_clear = 1'b0;
        chk("clr_only", 32'(m_err), 32'd0);

        // Reset in the middle of a group
        num_chan = 3'd2;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 12'hC55);
        cycle(1'b1, 1'b1, 12'hD55);
        do_reset();

        // Saturation of the error counter
        num_chan = 3'd1;
        cycle(1'b1, 1'b0, '0);
        for (int e = 0; e < ERR_MAX + 4; e++) begin
            cycle(1'b1, 1'b1, 12'(e));
            cycle(1'b1, 1'b1, 12'(e));
            cycle(1'b1, 1'b0, 12'(e));
        end
        chk("err_saturate", 32'(m_err), 32'(ERR_MAX));

        // Randomised traffic with occasional frame flips, channel changes and clears
        do_reset();
        tp = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) num_chan = 3'($urandom_range(0, 7));
            nce = (num_chan == 3'd0 || int'(num_chan) > MAX_CHAN) ? 1 : int'(num_chan);
            err_clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, 1'($urandom), 12'($urandom));
            end else begin
                f = (tp < nce);
                if ($urandom_range(0, 39) == 0) f = !f;
                cycle(1'b1, f, 12'($urandom));
                tp = (tp + 1) % (2 * nce);
            end
        end
        err_clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish (limit %0d ns)", 10000000);
        $fatal(1);
    end

endmodule
`default_nettype wire
